// File: rtl/pw_domain_seq.sv
// Power-domain sequencer: isolates, saves, switches off, and brings a switched
// power domain back up through restore, reset and de-isolation. A single
// 8-bit down-counter times the isolation hold, the domain reset hold and the
// power-switch acknowledge timeout. All outputs are registered state decodes.
module pw_domain_seq #(
  parameter int ISO_DLY    = 4,
  parameter int RST_CYC    = 3,
  parameter int SW_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pd_down_req,
  input  logic pd_up_req,
  input  logic pwr_sw_ack,
  input  logic err_clr,
  output logic pwr_sw_en,
  output logic iso_en,
  output logic save,
  output logic restore,
  output logic dom_rst,
  output logic pd_on,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [3:0] {
    ST_ON,
    ST_ISO,
    ST_SAVE,
    ST_SW_OFF,
    ST_OFF,
    ST_SW_ON,
    ST_RESTORE,
    ST_DRST,
    ST_DEISO,
    ST_ERR
  } pwState_e;

  localparam logic [7:0] IsoLoad = 8'(ISO_DLY);
  localparam logic [7:0] RstLoad = 8'(RST_CYC);
  localparam logic [7:0] SwLoad  = 8'(SW_TIMEOUT);

  pwState_e   state;
  pwState_e   nxtState;
  logic [7:0] cnt;
  logic [7:0] nxtCnt;
  logic       nxtDone;

  // Next-state, counter reload/decrement and completion-pulse decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    nxtState = state;
    nxtCnt   = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;

    case (state)
      ST_ON: begin
        // Down is the only request honoured here, so a simultaneous up
        // request is simply ignored.
        if (pd_down_req) nxtState = ST_ISO;
      end
      ST_ISO: begin
        if (cnt <= 8'd1) nxtState = ST_SAVE;
      end
      ST_SAVE: begin
        nxtState = ST_SW_OFF;
      end
      ST_SW_OFF: begin
        // Acknowledge is tested first so it wins over an expiring timeout.
        if (!pwr_sw_ack)       nxtState = ST_OFF;
        else if (cnt <= 8'd1)  nxtState = ST_ERR;
      end
      ST_OFF: begin
        if (pd_up_req) nxtState = ST_SW_ON;
      end
      ST_SW_ON: begin
        if (pwr_sw_ack)        nxtState = ST_RESTORE;
        else if (cnt <= 8'd1)  nxtState = ST_ERR;
      end
      ST_RESTORE: begin
        nxtState = ST_DRST;
      end
      ST_DRST: begin
        if (cnt <= 8'd1) nxtState = ST_DEISO;
      end
      ST_DEISO: begin
        nxtState = ST_ON;
      end
      ST_ERR: begin
        if (err_clr) nxtState = ST_OFF;
      end
      default: begin
        nxtState = ST_ON;
      end
    endcase

    // Counter reloads on every state entry with the budget of the new state.
    if (nxtState != state) begin
      case (nxtState)
        ST_ISO:              nxtCnt = IsoLoad;
        ST_DRST:             nxtCnt = RstLoad;
        ST_SW_OFF, ST_SW_ON: nxtCnt = SwLoad;
        default:             nxtCnt = 8'd0;
      endcase
    end

    nxtDone = ((state == ST_DEISO)  && (nxtState == ST_ON)) ||
              ((state == ST_SW_OFF) && (nxtState == ST_OFF));
  end

  // State, counter and registered output decode with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_ON;
      cnt       <= 8'd0;
      pwr_sw_en <= 1'b1;
      iso_en    <= 1'b0;
      save      <= 1'b0;
      restore   <= 1'b0;
      dom_rst   <= 1'b0;
      pd_on     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxtState;
      cnt   <= nxtCnt;
      done  <= nxtDone;

      // Outputs decode the state being entered so they line up with it.
      pwr_sw_en <= 1'b1;
      iso_en    <= 1'b1;
      save      <= 1'b0;
      restore   <= 1'b0;
      dom_rst   <= 1'b0;
      pd_on     <= 1'b0;
      busy      <= 1'b1;
      err       <= 1'b0;

      case (nxtState)
        ST_ON: begin
          iso_en <= 1'b0;
          pd_on  <= 1'b1;
          busy   <= 1'b0;
        end
        ST_SAVE: begin
          save <= 1'b1;
        end
        ST_SW_OFF: begin
          pwr_sw_en <= 1'b0;
        end
        ST_OFF: begin
          pwr_sw_en <= 1'b0;
          dom_rst   <= 1'b1;
          busy      <= 1'b0;
        end
        ST_SW_ON: begin
          dom_rst <= 1'b1;
        end
        ST_RESTORE: begin
          restore <= 1'b1;
          dom_rst <= 1'b1;
        end
        ST_DRST: begin
          dom_rst <= 1'b1;
        end
        ST_ERR: begin
          pwr_sw_en <= 1'b0;
          dom_rst   <= 1'b1;
          busy      <= 1'b0;
          err       <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pw_domain_seq.sv
// Testbench for pw_domain_seq: directed sequences with hand-computed cycle
// positions. Strobe events (save, restore, done, err entry) are checked by a
// scoreboard monitor; level checks compare the full output vector.
module tb_pw_domain_seq;

  logic clk = 1'b0;
  logic rst;
  logic pd_down_req;
  logic pd_up_req;
  logic pwr_sw_ack;
  logic err_clr;
  logic pwr_sw_en;
  logic iso_en;
  logic save;
  logic restore;
  logic dom_rst;
  logic pd_on;
  logic busy;
  logic done;
  logic err;

  pw_domain_seq #(
    .ISO_DLY    (4),
    .RST_CYC    (3),
    .SW_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pd_down_req (pd_down_req),
    .pd_up_req   (pd_up_req),
    .pwr_sw_ack  (pwr_sw_ack),
    .err_clr     (err_clr),
    .pwr_sw_en   (pwr_sw_en),
    .iso_en      (iso_en),
    .save        (save),
    .restore     (restore),
    .dom_rst     (dom_rst),
    .pd_on       (pd_on),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Output vector order: {pwr_sw_en, iso_en, save, restore, dom_rst, pd_on, busy, done, err}
  logic [8:0] obs;
  assign obs = {pwr_sw_en, iso_en, save, restore, dom_rst, pd_on, busy, done, err};

  localparam logic [8:0] V_ON    = 9'b100001000;
  localparam logic [8:0] V_ON_D  = 9'b100001010;
  localparam logic [8:0] V_ISO   = 9'b110000100;
  localparam logic [8:0] V_SAVE  = 9'b111000100;
  localparam logic [8:0] V_SWOFF = 9'b010000100;
  localparam logic [8:0] V_OFF   = 9'b010010000;
  localparam logic [8:0] V_OFF_D = 9'b010010010;
  localparam logic [8:0] V_SWON  = 9'b110010100;
  localparam logic [8:0] V_REST  = 9'b110110100;
  localparam logic [8:0] V_DRST  = 9'b110010100;
  localparam logic [8:0] V_DEISO = 9'b110000100;
  localparam logic [8:0] V_ERR   = 9'b010010001;

  typedef enum int {EV_SAVE, EV_RESTORE, EV_DONE, EV_ERR} evKind_e;
  typedef struct {
    evKind_e kind;
    int      cyc;
  } ev_t;

  ev_t expQ[$];
  int  testsRun  = 0;
  int  testsFail = 0;
  int  cyc       = 0;
  logic monOn    = 1'b0;
  logic errPrev  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic gotEvent(input evKind_e k);
    ev_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFail++;
      $display("FAIL unexpected event %s at cycle %0d: got event, expected none", k.name(), cyc);
    end else begin
      e = expQ.pop_front();
      check($sformatf("event kind (exp %s)", e.kind.name()), 32'(k), 32'(e.kind));
      check($sformatf("event %s cycle", e.kind.name()), 32'(cyc), 32'(e.cyc));
    end
  endtask

  task automatic pushEv(input evKind_e k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  task automatic waitTo(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Cycle counter: the value during a clock period names that cycle.
  always @(posedge clk) cyc++;

  // Scoreboard monitor: pops the expected queue whenever a strobe appears.
  always @(negedge clk) begin
    if (monOn) begin
      if (save)           gotEvent(EV_SAVE);
      if (restore)        gotEvent(EV_RESTORE);
      if (done)           gotEvent(EV_DONE);
      if (err && !errPrev) gotEvent(EV_ERR);
      errPrev = err;
    end
  end

  // Runaway guard.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int t0;

  // Directed stimulus; expected events are queued as each sequence is issued.
  initial begin
    rst         = 1'b1;
    pd_down_req = 1'b0;
    pd_up_req   = 1'b0;
    pwr_sw_ack  = 1'b1;
    err_clr     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state", obs, V_ON);
    rst   = 1'b0;
    monOn = 1'b1;
    @(negedge clk);
    check("idle ON", obs, V_ON);

    // Power-down sequence, ack falls at cycle 8.
    t0 = cyc;
    pd_down_req = 1'b1;
    pushEv(EV_SAVE, t0 + 5);
    pushEv(EV_DONE, t0 + 9);
    waitTo(t0 + 1); pd_down_req = 1'b0; check("ISO first cycle", obs, V_ISO);
    waitTo(t0 + 4); check("ISO last cycle", obs, V_ISO);
    waitTo(t0 + 5); check("SAVE strobe", obs, V_SAVE);
    waitTo(t0 + 6); check("SW_OFF entry", obs, V_SWOFF);
    waitTo(t0 + 8); check("SW_OFF waiting ack", obs, V_SWOFF); pwr_sw_ack = 1'b0;
    waitTo(t0 + 9); check("OFF with done", obs, V_OFF_D);
    waitTo(t0 + 10); check("OFF steady", obs, V_OFF); pd_down_req = 1'b1;
    waitTo(t0 + 11); pd_down_req = 1'b0; check("down in OFF dropped", obs, V_OFF);

    // Power-up sequence, ack rises at cycle 2.
    t0 = cyc;
    pd_up_req = 1'b1;
    pushEv(EV_RESTORE, t0 + 3);
    pushEv(EV_DONE, t0 + 8);
    waitTo(t0 + 1); pd_up_req = 1'b0; check("SW_ON entry", obs, V_SWON);
    waitTo(t0 + 2); check("SW_ON waiting ack", obs, V_SWON); pwr_sw_ack = 1'b1;
    waitTo(t0 + 3); check("RESTORE strobe", obs, V_REST);
    waitTo(t0 + 4); check("DRST first cycle", obs, V_DRST);
    waitTo(t0 + 6); check("DRST last cycle", obs, V_DRST);
    waitTo(t0 + 7); check("DEISO", obs, V_DEISO);
    waitTo(t0 + 8); check("ON with done", obs, V_ON_D);
    waitTo(t0 + 9); check("ON steady", obs, V_ON);

    // Both requests in ON act as down; up during ISO dropped; switch never
    // drops so SW_OFF times out into ERR.
    t0 = cyc;
    pd_down_req = 1'b1;
    pd_up_req   = 1'b1;
    pushEv(EV_SAVE, t0 + 5);
    pushEv(EV_ERR, t0 + 22);
    waitTo(t0 + 1); pd_down_req = 1'b0; pd_up_req = 1'b0; check("both reqs in ON -> ISO", obs, V_ISO);
    waitTo(t0 + 2); pd_up_req = 1'b1;
    waitTo(t0 + 3); pd_up_req = 1'b0; check("up in ISO dropped", obs, V_ISO);
    waitTo(t0 + 6); check("SW_OFF timeout start", obs, V_SWOFF);
    waitTo(t0 + 21); check("SW_OFF 16th cycle", obs, V_SWOFF);
    waitTo(t0 + 22); check("ERR after timeout", obs, V_ERR); pd_up_req = 1'b1;
    waitTo(t0 + 23); pd_up_req = 1'b0; check("up in ERR dropped", obs, V_ERR); err_clr = 1'b1;
    waitTo(t0 + 24); err_clr = 1'b0; check("err_clr -> OFF no done", obs, V_OFF);

    // Ack in the 16th SW_ON cycle wins over timeout; then reset inside DRST.
    t0 = cyc;
    pd_up_req  = 1'b1;
    pwr_sw_ack = 1'b0;
    pushEv(EV_RESTORE, t0 + 17);
    waitTo(t0 + 1); pd_up_req = 1'b0; check("SW_ON late-ack entry", obs, V_SWON);
    waitTo(t0 + 16); check("SW_ON 16th cycle", obs, V_SWON); pwr_sw_ack = 1'b1;
    waitTo(t0 + 17); check("ack wins over timeout", obs, V_REST);
    waitTo(t0 + 18); check("DRST before reset", obs, V_DRST); rst = 1'b1;
    waitTo(t0 + 19); rst = 1'b0; check("reset in DRST -> ON", obs, V_ON);
    waitTo(t0 + 25); check("ON after reset steady", obs, V_ON);
    check("expected events left", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
